// File: rtl/uart_pkg.sv
// Shared UART types and frame arithmetic for the transmitter and the future receiver.
// Pure declarations: no latency or flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned UART_PARITY_BITS = 1;
`else
    localparam int unsigned UART_PARITY_BITS = 0;
`endif

    // Clock cycles from the start bit's first cycle through the last stop cycle.
    function automatic int unsigned uart_frame_cycles(
        input int unsigned clks_per_bit,
        input int unsigned data_w,
        input int unsigned parity_bits,
        input int unsigned stop_bits
    );
        return clks_per_bit * (1 + data_w + parity_bits + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick in the last cycle of each CLKS_PER_BIT period while enabled.
// Zero latency on bit_tick; sync clear restarts the period, no backpressure.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (parity bit with UART_TX_PARITY_EN); start bit on tx the cycle after accept.
// Backpressure: tx_ready only in IDLE, so the source holds tx_valid/tx_data until the frame ends.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    uart_tx_state_e    state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BW-1:0]     bit_cnt, bit_cnt_d;
    logic              stop_cnt, stop_cnt_d;
    logic              tx_d;
    logic              accept;
    logic              bit_tick;

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .en      (tx_busy),
        .bit_tick(bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the word as accepted, before any shifting.
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= (^tx_data) ^ 1'(PARITY_ODD);
        end
    end
`endif

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shreg_d = tx_data;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        stop_cnt_d = 1'b0;
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_d = IDLE;
                        tx_done = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered, so it follows the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            tx       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: one-stop even-parity instance (a) and two-stop odd-parity instance (b).
module tb_uart_tx_param;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_a), .tx_data(data_a),
        .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_b), .tx_data(data_b),
        .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ready, tx, busy, done}
    function automatic logic [3:0] sample(input bit sel);
        return sel ? {ready_b, tx_b, busy_b, done_b} : {ready_a, tx_a, busy_a, done_a};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            valid_b = v;
            data_b  = d;
        end else begin
            valid_a = v;
            data_a  = d;
        end
    endtask

    task automatic push_bit(input logic b);
        for (int k = 0; k < CPB; k++) exp_q.push_back(b);
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge of the idle cycle after the frame.
    task automatic send(input bit sel, input string tag, input logic [7:0] w,
                        input bit hold, input logic [7:0] next_w, input int pulse_at);
        logic [3:0] o;
        logic       e;
        int         n;
        int         stops;
        bit         odd;
        stops = sel ? 2 : 1;
        odd   = sel;
        o = sample(sel);
        check($sformatf("%s_ready_pre", tag), o[3], 1'b1);
        drive(sel, 1'b1, w);
        @(posedge clk);
        #1;
        drive(sel, hold, hold ? next_w : ~w);
        exp_q.delete();
        push_bit(1'b0);
        for (int i = 0; i < DW; i++) push_bit(w[i]);
        if (PB == 1) push_bit((^w) ^ odd);
        for (int s = 0; s < stops; s++) push_bit(1'b1);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            o = sample(sel);
            e = exp_q.pop_front();
            check($sformatf("%s_tx_c%0d", tag, c), o[2], e);
            check($sformatf("%s_busy_c%0d", tag, c), o[1], 1'b1);
            check($sformatf("%s_done_c%0d", tag, c), o[0], (c == n));
            if (c == pulse_at) begin
                check($sformatf("%s_ready_busy", tag), o[3], 1'b0);
                drive(sel, 1'b1, 8'h55);
            end
            if (pulse_at > 0 && c == pulse_at + 1) drive(sel, 1'b0, 8'h00);
        end
        @(negedge clk);
        o = sample(sel);
        check($sformatf("%s_idle_ready", tag), o[3], 1'b1);
        check($sformatf("%s_idle_tx", tag), o[2], 1'b1);
        check($sformatf("%s_idle_busy", tag), o[1], 1'b0);
        check($sformatf("%s_idle_done", tag), o[0], 1'b0);
    endtask

    initial begin
        logic [3:0] o;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready_a", ready_a, 1'b1);
        check("rel_ready_b", ready_b, 1'b1);

        // Reset pulse while idle
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("idle_rst_tx", tx_a, 1'b1);
        check("idle_rst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rel_ready", ready_a, 1'b1);

        // Plain frame, then parity patterns on both instances
        send(1'b0, "a5", 8'hA5, 1'b0, 8'h00, 0);
        send(1'b0, "p07_even", 8'h07, 1'b0, 8'h00, 0);
        send(1'b1, "p07_odd", 8'h07, 1'b0, 8'h00, 0);

        // Back-to-back with tx_valid held across the frame boundary
        send(1'b0, "b2b_00", 8'h00, 1'b1, 8'hFF, 0);
        send(1'b0, "b2b_ff", 8'hFF, 1'b0, 8'h00, 0);

        // Reset during data bit 3 abandons the frame
        drive(1'b0, 1'b1, 8'hC3);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        o = sample(1'b0);
        check("mid_bit3_tx", o[2], 1'b0);
        check("mid_bit3_busy", o[1], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        o = sample(1'b0);
        check("mid_rst_tx", o[2], 1'b1);
        check("mid_rst_busy", o[1], 1'b0);
        check("mid_rst_done", o[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, "after_rst_3c", 8'h3C, 1'b0, 8'h00, 0);

        // Two stop bits, tx_valid pulsed mid-frame must be ignored
        send(1'b1, "stop2_96", 8'h96, 1'b0, 8'h00, 6);
        repeat (2) @(negedge clk);
        check("stop2_after_busy", busy_b, 1'b0);
        check("stop2_after_tx", tx_b, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
